// File: rtl/airlock_chamber_ctrl.sv
// Airlock chamber pressure controller.
//
// Moves the chamber between EVACUATED and PRESSURIZED through timed
// FILLING / EVACUATING phases. The countdown advances only on tick strobes.
// Both ports must stay closed for the whole phase. If either port opens,
// the phase is cancelled: the controller returns to the idle state it
// started from and pulses abort. The open_ok flags tell the port trackers
// which port may legally open.
//
// State table:
//   state      | meaning
//   EVAC_IDLE  | chamber at outer (water) pressure, outer port may open
//   FILLING    | timed fill phase toward vessel pressure, ports locked
//   PRESS_IDLE | chamber at inner (vessel) pressure, inner port may open
//   EVACUATING | timed evacuate phase toward water pressure, ports locked
//
// Ports:
//   Clock         system clock
//   Reset         synchronous, active-high reset
//   tick          one-cycle timing strobe that advances the countdown
//   begin_fill    one-cycle fill/pressurize request
//   begin_evac    one-cycle evacuate request
//   outer_closed  1 = outer port closed
//   inner_closed  1 = inner port closed
//   pressurized   chamber is in PRESS_IDLE
//   evacuated     chamber is in EVAC_IDLE
//   busy          fill or evacuate phase in progress
//   outer_open_ok outer port may open
//   inner_open_ok inner port may open
//   abort         one-cycle pulse after a phase is cancelled
//   remaining     ticks left in the current phase (0 when idle)
module airlock_chamber_ctrl #(
  parameter int FILL_TICKS = 7,
  parameter int EVAC_TICKS = 8,
  parameter int CNT_W      = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             tick,
  input  logic             begin_fill,
  input  logic             begin_evac,
  input  logic             outer_closed,
  input  logic             inner_closed,
  output logic             pressurized,
  output logic             evacuated,
  output logic             busy,
  output logic             outer_open_ok,
  output logic             inner_open_ok,
  output logic             abort,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    EVAC_IDLE  = 2'd0,
    FILLING    = 2'd1,
    PRESS_IDLE = 2'd2,
    EVACUATING = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] FILL_LOAD = CNT_W'(FILL_TICKS);
  localparam logic [CNT_W-1:0] EVAC_LOAD = CNT_W'(EVAC_TICKS);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_d;
  logic             abort_d;
  logic             both_closed;

  assign both_closed = outer_closed & inner_closed;

  always_comb begin
    state_d = state_q;
    rem_d   = remaining;
    abort_d = 1'b0;
    case (state_q)
      EVAC_IDLE: begin
        // A tick on the accepting edge is not counted: the counter loads
        // the full phase length regardless of tick.
        if (begin_fill && both_closed) begin
          state_d = FILLING;
          rem_d   = FILL_LOAD;
        end
      end
      FILLING: begin
        // Port loss has priority over the tick, including the final tick.
        if (!both_closed) begin
          state_d = EVAC_IDLE;
          rem_d   = '0;
          abort_d = 1'b1;
        end else if (tick) begin
          if (remaining <= ONE) begin
            state_d = PRESS_IDLE;
            rem_d   = '0;
          end else begin
            rem_d = remaining - ONE;
          end
        end
      end
      PRESS_IDLE: begin
        if (begin_evac && both_closed) begin
          state_d = EVACUATING;
          rem_d   = EVAC_LOAD;
        end
      end
      EVACUATING: begin
        if (!both_closed) begin
          state_d = PRESS_IDLE;
          rem_d   = '0;
          abort_d = 1'b1;
        end else if (tick) begin
          if (remaining <= ONE) begin
            state_d = EVAC_IDLE;
            rem_d   = '0;
          end else begin
            rem_d = remaining - ONE;
          end
        end
      end
      default: begin
        state_d = EVAC_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Status flags are decoded from the next state so that they change on
  // the same edge as the state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= EVAC_IDLE;
      remaining     <= '0;
      abort         <= 1'b0;
      evacuated     <= 1'b1;
      outer_open_ok <= 1'b1;
      pressurized   <= 1'b0;
      inner_open_ok <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining     <= rem_d;
      abort         <= abort_d;
      evacuated     <= (state_d == EVAC_IDLE);
      outer_open_ok <= (state_d == EVAC_IDLE);
      pressurized   <= (state_d == PRESS_IDLE);
      inner_open_ok <= (state_d == PRESS_IDLE);
      busy          <= (state_d == FILLING) || (state_d == EVACUATING);
    end
  end

endmodule

// File: tb/tb_airlock_chamber_ctrl.sv
module tb_airlock_chamber_ctrl;

  logic       Clock = 1'b0;
  logic       Reset, tick, begin_fill, begin_evac, outer_closed, inner_closed;
  logic       pressurized, evacuated, busy, outer_open_ok, inner_open_ok, abort;
  logic [3:0] remaining;

  int n_tests = 0;
  int n_fail  = 0;

  // flags = {pressurized, evacuated, busy, outer_open_ok, inner_open_ok, abort}
  localparam logic [5:0] F_EIDLE = 6'b010100;
  localparam logic [5:0] F_PIDLE = 6'b100010;
  localparam logic [5:0] F_BUSY  = 6'b001000;
  localparam logic [5:0] F_EABRT = 6'b010101;
  localparam logic [5:0] F_PABRT = 6'b100011;

  typedef struct {
    logic       rst, tk, bf, be, oc, ic;
    logic [5:0] flags;
    logic [3:0] rem;
  } vec_t;

  vec_t vecs[64];
  int   n_vec = 0;

  airlock_chamber_ctrl #(.FILL_TICKS(7), .EVAC_TICKS(8), .CNT_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .tick(tick),
    .begin_fill(begin_fill), .begin_evac(begin_evac),
    .outer_closed(outer_closed), .inner_closed(inner_closed),
    .pressurized(pressurized), .evacuated(evacuated), .busy(busy),
    .outer_open_ok(outer_open_ok), .inner_open_ok(inner_open_ok),
    .abort(abort), .remaining(remaining)
  );

  always #5 Clock = ~Clock;

  task automatic add(input logic rst, tk, bf, be, oc, ic,
                     input logic [5:0] flags, input logic [3:0] rem);
    vecs[n_vec] = '{rst, tk, bf, be, oc, ic, flags, rem};
    n_vec++;
  endtask

  // Drive inputs after a falling edge; outputs are sampled on the next
  // falling edge, i.e. half a period after the rising edge that used them.
  task automatic cyc(input logic rst, tk, bf, be, oc, ic);
    Reset = rst; tick = tk; begin_fill = bf; begin_evac = be;
    outer_closed = oc; inner_closed = ic;
    @(negedge Clock);
  endtask

  task automatic chk(input string name, input logic [5:0] flags, input logic [3:0] rem);
    logic [5:0] act;
    act = {pressurized, evacuated, busy, outer_open_ok, inner_open_ok, abort};
    n_tests++;
    if (act !== flags || remaining !== rem) begin
      n_fail++;
      $display("FAIL %s: got flags=%b rem=%0d, want flags=%b rem=%0d",
               name, act, remaining, flags, rem);
    end
  endtask

  initial begin
    //  rst tk bf be oc ic  flags    rem
    add(1, 0, 0, 0, 1, 1, F_EIDLE, 0);   // reset
    add(0, 0, 0, 0, 1, 1, F_EIDLE, 0);
    add(0, 0, 1, 0, 0, 1, F_EIDLE, 0);   // fill with outer open: ignored
    add(0, 0, 1, 1, 1, 1, F_BUSY,  7);   // fill+evac together: fill taken
    add(0, 1, 0, 0, 1, 1, F_BUSY,  6);
    add(0, 1, 0, 0, 1, 1, F_BUSY,  5);
    add(0, 1, 0, 0, 1, 1, F_BUSY,  4);
    add(0, 1, 0, 0, 1, 1, F_BUSY,  3);
    add(0, 0, 0, 0, 1, 0, F_EABRT, 0);   // inner opens at rem=3
    add(0, 0, 0, 0, 1, 1, F_EIDLE, 0);   // abort lasts one cycle
    add(0, 1, 1, 0, 1, 1, F_BUSY,  7);   // accepting-edge tick not counted
    add(0, 0, 0, 1, 1, 1, F_BUSY,  7);   // request during fill ignored
    for (int r = 6; r >= 1; r--) add(0, 1, 0, 0, 1, 1, F_BUSY, 4'(r));
    add(0, 1, 0, 0, 1, 1, F_PIDLE, 0);   // 7th tick completes
    add(0, 0, 1, 0, 1, 1, F_PIDLE, 0);   // fill from PRESS_IDLE ignored
    add(0, 0, 0, 1, 0, 1, F_PIDLE, 0);   // evac with outer open ignored
    add(0, 0, 0, 1, 1, 1, F_BUSY,  8);
    for (int r = 7; r >= 4; r--) add(0, 1, 0, 0, 1, 1, F_BUSY, 4'(r));
    add(1, 0, 0, 0, 0, 1, F_EIDLE, 0);   // reset mid-evac: no abort
    add(0, 0, 0, 0, 1, 1, F_EIDLE, 0);

    Reset = 1'b1; tick = 0; begin_fill = 0; begin_evac = 0;
    outer_closed = 1; inner_closed = 1;
    @(negedge Clock);

    for (int i = 0; i < n_vec; i++) begin
      cyc(vecs[i].rst, vecs[i].tk, vecs[i].bf, vecs[i].be, vecs[i].oc, vecs[i].ic);
      chk($sformatf("vec%0d", i), vecs[i].flags, vecs[i].rem);
    end

    // Full fill with ticks spaced 5 cycles apart.
    cyc(0, 0, 1, 0, 1, 1); chk("spaced_accept", F_BUSY, 7);
    for (int k = 1; k <= 7; k++) begin
      for (int g = 0; g < 4; g++) begin
        cyc(0, 0, 0, 0, 1, 1); chk($sformatf("spaced_hold%0d", k), F_BUSY, 4'(8 - k));
      end
      cyc(0, 1, 0, 0, 1, 1);
      if (k < 7) chk($sformatf("spaced_tick%0d", k), F_BUSY, 4'(7 - k));
      else       chk("spaced_done", F_PIDLE, 0);
    end

    // Full evacuate with 8 ticks, then a second evac request is ignored.
    cyc(0, 0, 0, 1, 1, 1); chk("evac_accept", F_BUSY, 8);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 1, 0, 0, 1, 1);
      if (k < 8) chk($sformatf("evac_tick%0d", k), F_BUSY, 4'(8 - k));
      else       chk("evac_done", F_EIDLE, 0);
    end
    cyc(0, 0, 0, 1, 1, 1); chk("evac_again_ignored", F_EIDLE, 0);

    // Outer port opens on the final fill tick: abort wins.
    cyc(0, 0, 1, 0, 1, 1);
    for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 1, 1);
    chk("fill_last_rem1", F_BUSY, 1);
    cyc(0, 1, 0, 0, 0, 1); chk("fill_final_tick_abort", F_EABRT, 0);
    cyc(0, 0, 0, 0, 1, 1); chk("fill_abort_clears", F_EIDLE, 0);

    // Inner port opens on the final evacuate tick: back to PRESS_IDLE.
    cyc(0, 0, 1, 0, 1, 1);
    for (int k = 0; k < 7; k++) cyc(0, 1, 0, 0, 1, 1);
    chk("refill_done", F_PIDLE, 0);
    cyc(0, 0, 0, 1, 1, 1);
    for (int k = 0; k < 7; k++) cyc(0, 1, 0, 0, 1, 1);
    chk("evac_last_rem1", F_BUSY, 1);
    cyc(0, 1, 0, 0, 1, 0); chk("evac_final_tick_abort", F_PABRT, 0);
    cyc(0, 0, 0, 0, 1, 1); chk("evac_abort_clears", F_PIDLE, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/airlock_chamber_ctrl.md
Name: airlock_chamber_ctrl

Overview:
- Chamber pressure controller for the airlock interlock.
- Sits downstream of the port open/close trackers (outer/inner port state) and the single-pulse key conditioners (fill/evacuate requests).
- Sequences the chamber between EVACUATED and PRESSURIZED through timed FILLING/EVACUATING phases.
- Enforces that both ports are closed for the whole transition and publishes which port may legally open.

Parameters:
- FILL_TICKS, 7, number of tick strobes a fill/pressurize phase lasts (1..2^CNT_W-1)
- EVAC_TICKS, 8, number of tick strobes an evacuate phase lasts (1..2^CNT_W-1)
- CNT_W, 4, width of the phase countdown

Ports:
- Clock  input  1  system clock (CLOCK_50 domain); the only clock.
- Reset  input  1  synchronous, active-high reset.
- tick  input  1  one-Clock-wide timing strobe (e.g. ~1 Hz from the divider edge); countdown advances only on tick.
- begin_fill  input  1  one-cycle request to fill and pressurize.
- begin_evac  input  1  one-cycle request to evacuate.
- outer_closed  input  1  1 = outer port closed.
- inner_closed  input  1  1 = inner port closed.
- pressurized  output  1  chamber at inner (vessel) pressure.
- evacuated  output  1  chamber at outer (water) pressure.
- busy  output  1  fill or evacuate in progress.
- outer_open_ok  output  1  outer port may open.
- inner_open_ok  output  1  inner port may open.
- abort  output  1  one-cycle pulse when a phase is cancelled.
- remaining  output  CNT_W  ticks left in the current phase (0 when idle), for HEX display.

Behaviour:
- States: EVAC_IDLE, FILLING, PRESS_IDLE, EVACUATING. All state and outputs are registered and updated on the rising edge of Clock.
- Reset (sync, highest priority): state=EVAC_IDLE, remaining=0, abort=0. Reset mid-phase cancels the phase without raising abort.
- Decode:
  - evacuated = EVAC_IDLE
  - pressurized = PRESS_IDLE
  - busy = FILLING | EVACUATING
  - outer_open_ok = EVAC_IDLE
  - inner_open_ok = PRESS_IDLE
  - Values after reset: evacuated=1, outer_open_ok=1, all other flags 0.
- both_closed = outer_closed & inner_closed.
- EVAC_IDLE:
  - begin_fill & both_closed -> FILLING, remaining=FILL_TICKS at the next edge.
  - begin_fill with any port open: ignored, no abort.
  - begin_evac: ignored.
- FILLING, checked in this order:
  1. !both_closed -> EVAC_IDLE, remaining=0, abort=1 for one cycle.
  2. Else on tick: remaining-1. If remaining==1 when the tick arrives -> PRESS_IDLE, remaining=0.
  3. Else hold.
  - Requests received during FILLING are ignored.
- PRESS_IDLE: mirror of EVAC_IDLE.
  - begin_evac & both_closed -> EVACUATING, remaining=EVAC_TICKS.
  - begin_fill: ignored.
- EVACUATING: mirror of FILLING. A port opening returns to PRESS_IDLE with abort.
- Phase length: exactly FILL_TICKS (EVAC_TICKS) tick strobes after acceptance. A tick coincident with the accepting edge is not counted.
- Simultaneous begin_fill & begin_evac: only the request legal in the current state is acted on; the other is dropped.
- Port opening coincident with the final tick: abort wins; the phase does not complete.
- abort is 0 in every cycle except the one following a cancellation edge.
- remaining never wraps. It is loaded only from the parameters and decremented only while > 0.
- Ports opening while idle have no effect on state. The open_ok flags are advisory; the port trackers gate on them.

Test Plan:
- Reset, then observe -> evacuated=1, outer_open_ok=1, pressurized=0, busy=0, remaining=0.
- Both ports closed, pulse begin_fill, apply 7 ticks spaced 5 cycles apart -> remaining goes 7,6,…,1. pressurized=1 and inner_open_ok=1 one edge after the 7th tick. busy=1 throughout the phase.
- From PRESS_IDLE, pulse begin_evac, apply 8 ticks -> evacuated=1 after the 8th tick. Then pulse begin_evac again -> ignored.
- During FILLING at remaining=3, drop inner_closed -> next edge: state EVAC_IDLE, abort=1 for exactly one cycle, remaining=0.
- From EVAC_IDLE with outer_closed=0, pulse begin_fill -> no state change and no abort. Separately, pulse begin_fill and begin_evac together with both ports closed -> FILLING entered.
- Assert Reset while EVACUATING at remaining=4 -> evacuated=1, remaining=0, abort=0. Also check: port opens on the same edge as the final tick -> abort, state returns to the origin idle state.
